// File: rtl/shift_seq_pkg.sv
// Shared constants and sizing helpers for the Johnson / one-hot ring sequence generator.
package shift_seq_pkg;

    localparam logic MODE_JOHNSON = 1'b0;
    localparam logic MODE_RING    = 1'b1;

    // Sequence length before the pattern repeats.
    function automatic int seq_period(input int n, input logic mode);
        return (mode == MODE_RING) ? n : 2 * n;
    endfunction

    // Width of the step counter; sized for the longer (Johnson) period.
    function automatic int step_width(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/shift_seq_chk.sv
// Combinational legality check of a sequence state for the selected mode.
module shift_seq_chk
    import shift_seq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] state,
    input  logic         mode,
    output logic         legal
);

    int transitions;
    int ones;

    // Johnson states have at most one edge between adjacent bits (not circular).
    always_comb begin
        transitions = 0;
        ones        = 0;
        for (int i = 0; i < N - 1; i++) begin
            if (state[i] != state[i+1]) transitions++;
        end
        for (int i = 0; i < N; i++) begin
            if (state[i]) ones++;
        end
        if (mode == MODE_RING) legal = (ones == 1);
        else                   legal = (transitions <= 1);
    end

endmodule

// File: rtl/shift_seq_gen.sv
// Johnson / one-hot ring sequence generator with load, self-correction and step tracking.
module shift_seq_gen
    import shift_seq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     mode,
    input  logic                     dir,
    input  logic                     load,
    input  logic [N-1:0]             load_val,
    output logic [N-1:0]             Q,
    output logic [step_width(N)-1:0] step,
    output logic                     wrap,
    output logic                     err
);

    localparam int STEP_W = step_width(N);

    logic             mode_q;
    logic             legal;
    logic [N-1:0]     johnson_next;
    logic [N-1:0]     ring_next;
    logic [N-1:0]     advance_next;
    logic [STEP_W-1:0] last_step;

    function automatic logic [N-1:0] start_pattern(input logic m);
        return (m == MODE_RING) ? {{(N-1){1'b0}}, 1'b1} : '0;
    endfunction

    // Legality is judged against the mode in effect, not the mode input.
    shift_seq_chk #(.N(N)) u_chk (
        .state (Q),
        .mode  (mode_q),
        .legal (legal)
    );

    always_comb begin
        johnson_next = Q;
        ring_next    = Q;
        if (dir == 1'b0) begin
            johnson_next = {Q[N-2:0], ~Q[N-1]};
            ring_next    = {Q[N-2:0],  Q[N-1]};
        end else begin
            johnson_next = {~Q[0], Q[N-1:1]};
            ring_next    = { Q[0], Q[N-1:1]};
        end
        advance_next = (mode_q == MODE_RING) ? ring_next : johnson_next;
    end

    assign last_step = STEP_W'(seq_period(N, mode_q) - 1);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            Q      <= '0;
            step   <= '0;
            wrap   <= 1'b0;
            err    <= 1'b0;
            mode_q <= MODE_JOHNSON;
        end else if (load) begin
            Q      <= load_val;
            mode_q <= mode;
            step   <= '0;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else if (mode != mode_q) begin
            Q      <= start_pattern(mode);
            mode_q <= mode;
            step   <= '0;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else if (!legal) begin
            // Recovery happens even while idle so a corrupted state never lingers.
            Q      <= start_pattern(mode_q);
            step   <= '0;
            wrap   <= 1'b0;
            err    <= 1'b1;
        end else if (en) begin
            Q <= advance_next;
            if (step == last_step) begin
                step <= '0;
                wrap <= 1'b1;
            end else begin
                step <= step + 1'b1;
                wrap <= 1'b0;
            end
            err <= 1'b0;
        end else begin
            wrap <= 1'b0;
            err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_seq_gen.sv
// Table-driven, scoreboard-checked bench for shift_seq_gen at N=4.
module tb_shift_seq_gen;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         clr;
    logic         en, mode, dir, load;
    logic [N-1:0] load_val;
    logic [N-1:0] Q;
    logic [2:0]   step;
    logic         wrap, err;

    typedef struct {
        logic         ld;
        logic         en;
        logic         md;
        logic         dr;
        logic [N-1:0] lv;
        logic [N-1:0] q;
        logic [2:0]   st;
        logic         w;
        logic         e;
    } vec_t;

    vec_t table_q[$];
    vec_t expect_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    shift_seq_gen #(.N(N)) dut (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .Q        (Q),
        .step     (step),
        .wrap     (wrap),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic add(input logic ld, input logic e_n, input logic md, input logic dr,
                       input logic [N-1:0] lv, input logic [N-1:0] q, input logic [2:0] st,
                       input logic w, input logic e);
        vec_t v;
        v.ld = ld; v.en = e_n; v.md = md; v.dr = dr; v.lv = lv;
        v.q = q; v.st = st; v.w = w; v.e = e;
        table_q.push_back(v);
    endtask

    task automatic check_now(input string name, input logic [N-1:0] q, input logic [2:0] st,
                             input logic w, input logic e);
        n_vec++;
        if (Q !== q || step !== st || wrap !== w || err !== e) begin
            n_bad++;
            $display("FAIL %s: got Q=%b step=%0d wrap=%b err=%b, want Q=%b step=%0d wrap=%b err=%b",
                     name, Q, step, wrap, err, q, st, w, e);
        end
    endtask

    task automatic step_here(input string name, input vec_t v);
        vec_t x;
        load = v.ld; en = v.en; mode = v.md; dir = v.dr; load_val = v.lv;
        expect_q.push_back(v);
        @(posedge clk);
        #1;
        if (expect_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            x = expect_q.pop_front();
            check_now(name, x.q, x.st, x.w, x.e);
        end
    endtask

    task automatic drive_step(input string name, input vec_t v);
        @(negedge clk);
        step_here(name, v);
    endtask

    function automatic vec_t mk(input logic ld, input logic e_n, input logic md, input logic dr,
                                input logic [N-1:0] lv, input logic [N-1:0] q,
                                input logic [2:0] st, input logic w, input logic e);
        vec_t v;
        v.ld = ld; v.en = e_n; v.md = md; v.dr = dr; v.lv = lv;
        v.q = q; v.st = st; v.w = w; v.e = e;
        return v;
    endfunction

    initial begin
        // Johnson, toward MSB, from reset
        add(0,1,0,0,4'h0, 4'b0001,1,0,0);
        add(0,1,0,0,4'h0, 4'b0011,2,0,0);
        add(0,1,0,0,4'h0, 4'b0111,3,0,0);
        add(0,1,0,0,4'h0, 4'b1111,4,0,0);
        add(0,1,0,0,4'h0, 4'b1110,5,0,0);
        add(0,1,0,0,4'h0, 4'b1100,6,0,0);
        add(0,1,0,0,4'h0, 4'b1000,7,0,0);
        add(0,1,0,0,4'h0, 4'b0000,0,1,0);
        add(0,0,0,0,4'h0, 4'b0000,0,0,0);
        // Johnson, toward LSB
        add(0,1,0,1,4'h0, 4'b1000,1,0,0);
        add(0,1,0,1,4'h0, 4'b1100,2,0,0);
        add(0,1,0,1,4'h0, 4'b1110,3,0,0);
        add(0,1,0,1,4'h0, 4'b1111,4,0,0);
        add(0,1,0,1,4'h0, 4'b0111,5,0,0);
        add(0,1,0,1,4'h0, 4'b0011,6,0,0);
        add(0,1,0,1,4'h0, 4'b0001,7,0,0);
        add(0,1,0,1,4'h0, 4'b0000,0,1,0);
        // Switch to ring: mode change beats en
        add(0,1,1,0,4'h0, 4'b0001,0,0,0);
        add(0,1,1,0,4'h0, 4'b0010,1,0,0);
        add(0,1,1,0,4'h0, 4'b0100,2,0,0);
        add(0,1,1,0,4'h0, 4'b1000,3,0,0);
        add(0,1,1,0,4'h0, 4'b0001,0,1,0);
        add(0,1,1,1,4'h0, 4'b1000,1,0,0);
        add(0,0,1,1,4'h0, 4'b1000,1,0,0);
        // Illegal ring load, corrected even with en=1
        add(1,0,1,0,4'b0110, 4'b0110,0,0,0);
        add(0,1,1,0,4'h0,    4'b0001,0,0,1);
        add(0,0,1,0,4'h0,    4'b0001,0,0,0);
        // Illegal Johnson load corrected while idle
        add(1,0,0,0,4'b0101, 4'b0101,0,0,0);
        add(0,0,0,0,4'h0,    4'b0000,0,0,1);
        add(0,0,0,0,4'h0,    4'b0000,0,0,0);
        // Load beats en, then hold
        add(1,1,0,0,4'b0011, 4'b0011,0,0,0);
        add(0,0,0,0,4'h0,    4'b0011,0,0,0);
        add(0,0,0,0,4'h0,    4'b0011,0,0,0);
        add(0,0,0,0,4'h0,    4'b0011,0,0,0);
        add(0,1,0,0,4'h0,    4'b0111,1,0,0);

        clr = 1'b0; en = 0; mode = 0; dir = 0; load = 0; load_val = '0;
        #2;
        check_now("reset_state", 4'b0000, 0, 0, 0);
        #10 clr = 1'b1;

        for (int i = 0; i < table_q.size(); i++) begin
            drive_step($sformatf("vec%0d", i), table_q[i]);
        end

        // Async clear mid-sequence at Q=0111, no clock edge involved
        drive_step("rst_load", mk(1,0,0,0,4'b0000, 4'b0000,0,0,0));
        drive_step("rst_a1",   mk(0,1,0,0,4'h0,    4'b0001,1,0,0));
        drive_step("rst_a2",   mk(0,1,0,0,4'h0,    4'b0011,2,0,0));
        drive_step("rst_a3",   mk(0,1,0,0,4'h0,    4'b0111,3,0,0));
        @(negedge clk);
        #1 clr = 1'b0;
        #1 check_now("async_clear", 4'b0000, 0, 0, 0);
        #1 clr = 1'b1;
        step_here("restart1", mk(0,1,0,0,4'h0, 4'b0001,1,0,0));
        drive_step("restart2", mk(0,1,0,0,4'h0, 4'b0011,2,0,0));

        // Ring selected across reset: first edge applies the mode change
        @(negedge clk);
        mode = 1'b1; en = 1'b0;
        #1 clr = 1'b0;
        #1 check_now("ring_reset", 4'b0000, 0, 0, 0);
        #1 clr = 1'b1;
        step_here("ring_first", mk(0,0,1,0,4'h0, 4'b0001,0,0,0));
        drive_step("ring_r1", mk(0,1,1,0,4'h0, 4'b0010,1,0,0));
        drive_step("ring_r2", mk(0,1,1,0,4'h0, 4'b0100,2,0,0));
        drive_step("ring_r3", mk(0,1,1,0,4'h0, 4'b1000,3,0,0));
        // Clear just before the wrap: no pulse after release
        @(negedge clk);
        #1 clr = 1'b0;
        #1 check_now("ring_clear", 4'b0000, 0, 0, 0);
        #1 clr = 1'b1;
        step_here("ring_rel", mk(0,1,1,0,4'h0, 4'b0001,0,0,0));
        drive_step("ring_r4", mk(0,1,1,0,4'h0, 4'b0010,1,0,0));

        if (expect_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, want 0", expect_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/shift_seq_gen.md
SHIFT_SEQ_GEN -- requirements
Module: shift_seq_gen

Interface
REQ-001 Parameter N, default 8, register width in bits; legal range 2..64.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 clr  input  1  asynchronous, active-low reset; clears all state immediately on falling edge, independent of clk.
REQ-004 en  input  1  advance enable; one sequence step per enabled clock.
REQ-005 mode  input  1  sequence select: 0 = Johnson (twisted ring, period 2N), 1 = one-hot ring (period N).
REQ-006 dir  input  1  shift direction: 0 = toward MSB, 1 = toward LSB.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 load_val  input  N  value captured on load.
REQ-009 Q  output  N  current sequence state, registered.
REQ-010 step  output  clog2(2N)  steps taken since start pattern, modulo period, registered.
REQ-011 wrap  output  1  one-cycle pulse, registered, on return to step 0 by advance.
REQ-012 err  output  1  one-cycle pulse, registered, on illegal-state correction.

Function
REQ-013 Start pattern: Johnson all-zeros; ring 0...01.
REQ-014 Johnson advance: dir=0 Q <= {Q[N-2:0], ~Q[N-1]}; dir=1 Q <= {~Q[0], Q[N-1:1]}.
REQ-015 Ring advance: dir=0 rotate left by one; dir=1 rotate right by one.
REQ-016 Legal Johnson state: at most one bit-value transition between adjacent bits, non-circular. Legal ring state: popcount exactly 1.
REQ-017 Internal register mode_q holds the mode in effect; period = 2N when mode_q=0, N when mode_q=1.
REQ-018 Per-edge priority, highest first: load; mode != mode_q; Q illegal for mode_q; en; hold.
REQ-019 Load: Q <= load_val, mode_q <= mode, step <= 0, wrap <= 0, err <= 0; load_val not checked on this edge.
REQ-020 Mode change: Q <= start pattern of new mode, mode_q <= mode, step <= 0, wrap <= 0, err <= 0.
REQ-021 Illegal state (load=0, no mode change): Q <= start pattern, step <= 0, err <= 1, wrap <= 0; applies regardless of en.
REQ-022 Advance (en=1): Q per REQ-014/015; step <= step+1, or 0 when step = period-1; wrap <= 1 on that rollover only.
REQ-023 Direction affects only Q; step always counts up; dir may change on any cycle without reinitialisation.
REQ-024 Hold (en=0): Q, step, mode_q unchanged; wrap <= 0, err <= 0.
REQ-025 wrap and err never both 1 on the same cycle.
REQ-026 Latency: every change on an input is visible on Q/step/wrap/err after exactly one rising edge; no combinational input-to-output path.

Reset
REQ-027 clr=0: Q=0, step=0, wrap=0, err=0, mode_q=0 (Johnson), asynchronously.
REQ-028 First edge after clr release: if mode=1, mode-change rule (REQ-020) applies, giving Q=0...01.
REQ-029 clr asserted mid-sequence discards all state; no pulse is emitted on or after release.

Structure
REQ-030 Shared package shift_seq_pkg: mode constants MODE_JOHNSON, MODE_RING; period function of N and mode; step-width function clog2(2N).
REQ-031 One combinational sub-module shift_seq_chk (inputs N-bit state, mode; output legal) implementing REQ-016.
REQ-032 All remaining logic in one clocked process with asynchronous clr.

Verification (N=4)
REQ-033 Johnson, dir=0, en=1 from reset: Q 0000,0001,0011,0111,1111,1110,1100,1000,0000; wrap=1 only with the final 0000, step=0.
REQ-034 Johnson, dir=1 from reset: Q 0000,1000,1100,1110,1111,0111,0011,0001,0000; step 0..7 then 0.
REQ-035 mode=1 after reset: first edge Q=0001, step=0; then 0010,0100,1000,0001 with wrap=1 on 0001.
REQ-036 Johnson, load with load_val=0101: Q=0101; next edge with en=0: Q=0000, err=1 for one cycle, then err=0.
REQ-037 load=1 and en=1 together, load_val=0011: Q=0011, step=0, no advance; en=0 for 3 cycles: Q, step held, no pulses.
REQ-038 clr driven low between edges mid-sequence (Q=0111): Q=0000 at once, without a clock edge; after release, Johnson sequence restarts from step 0.
